mon_drain: RTL and testbench
============================

# mon_drain

Read-side drain engine for the monitor data FIFO. It owns the FIFO read pointer and issues read requests to the FIFO arbiter. Each 18-bit sample it reads is serialised into three tagged bytes on a valid/ready byte stream that feeds the monitor UART transmitter. The write side (sampler, `waddr`/`wrreq`) stays upstream; this block never writes the FIFO.

## Interface
- No parameters; widths fixed: address 11 bits, data 18 bits, byte 8 bits.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mon_en`  in  1  high = drain enabled.
- `flush`  in  1  high for one or more cycles = discard FIFO contents.
- `empty`  in  1  FIFO empty flag, combinational from `raddr == waddr`.
- `waddr`  in  11  current FIFO write pointer, used only by flush.
- `rdreq`  out  1  FIFO read request.
- `rdack`  in  1  read granted this cycle; a write has priority, so `rdack` can be low while `rdreq` is high.
- `raddr`  out  11  FIFO read pointer, registered.
- `rdata`  in  18  RAM read data, valid the cycle after an `rdack` cycle.
- `tx_valid`  out  1  byte available.
- `tx_ready`  in  1  UART accepts the byte.
- `tx_data`  out  8  byte.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, REQ, WAIT, B0, B1, B2, plus SYNC when configured.
- IDLE: if `mon_en & ~empty`, go to REQ; otherwise stay.
- REQ: `rdreq` = 1, decoded from state. Stay while `rdack` = 0. On `rdack` = 1, go to WAIT.
- WAIT: capture `rdata` into the 18-bit word register and set `raddr <= raddr + 1`. The increment is modulo 2^11, so 0x7FF wraps to 0x000. Then go to B0, or to SYNC when configured and due.
- Byte format, where d is the captured word. The top two bits are a tag for receiver resync:
  - B0: `{2'b11, d[17:12]}`
  - B1: `{2'b10, d[11:6]}`
  - B2: `{2'b00, d[5:0]}`
- In each B state, `tx_valid` = 1 and `tx_data` is held stable until `tx_ready` = 1. The handshake completes on a cycle where both are high, then the state advances: B0 to B1, B1 to B2, B2 to IDLE.
- `tx_data` and `tx_valid` are registered outputs.
- Dropping `mon_en` mid-word does not abort. The current word completes through B2 and the block then stays in IDLE.
- `flush`, in any state: `raddr <= waddr`, state goes to IDLE, `tx_valid <= 0`.
  - Any partially sent word is abandoned. This is the only case where `tx_valid` falls without a handshake.
  - The sync counter is cleared.
- Priority: `rst` > `flush` > normal operation.
- Empty boundary: `empty` is sampled only in IDLE. The block never issues `rdreq` while `empty` = 1 is seen in IDLE.
- Full boundary: nothing to handle here. Full is the writer's concern, and the increment in WAIT frees one slot.
- A simultaneous write (`wrreq`) during REQ only delays `rdack`. No data is lost.

## Timing
- Reset values: `rdreq` 0, `raddr` 0x000, `tx_valid` 0, `tx_data` 0x00, `busy` 0, state IDLE, word register 0.
- `rst` asserted mid-word returns every output to these values on the next edge.
- Latency with no write contention and `tx_ready` held high:
  - cycle n: IDLE sees `~empty`.
  - n+1: `rdreq` = 1 and `rdack` = 1.
  - n+2: WAIT, capture.
  - n+3, n+4, n+5: B0, B1, B2 present `tx_valid`.
  - n+6: back in IDLE.
  - Sustained throughput: one word per 6 cycles.
- Each write-contention cycle adds one cycle in REQ.
- `raddr` changes only at the WAIT edge or on flush or reset.

## Configuration
- `MON_DRAIN_SYNC_EN` defined:
  - A 6-bit counter increments at every WAIT capture.
  - When the counter is 0 at capture, WAIT goes to SYNC instead of B0.
  - SYNC presents byte 0x7E, tag `01`, with the same handshake as the B states, then goes to B0.
  - The first word after reset or flush is therefore preceded by 0x7E, and so is every 64th word after it.
- Not defined: no SYNC state, no counter, WAIT always goes to B0.

## Test plan
- Reset, then `empty` = 1 with `mon_en` = 1 for 20 cycles -> `rdreq` stays 0, `tx_valid` 0, `raddr` 0x000.
- One word 0x2A5C3 in the FIFO, `tx_ready` = 1 -> bytes 0xEA, 0x97, 0x03 on cycles n+3..n+5 (plus 0x7E first if `MON_DRAIN_SYNC_EN`); `raddr` = 0x001.
- `tx_ready` low for 5 cycles during B1 -> `tx_data` is held at B1's byte and `tx_valid` stays 1 for the whole stall; the sequence then completes.
- `rdack` held low 3 cycles while in REQ (write contention) -> `rdreq` stays high, capture happens the cycle after `rdack` rises, and the data is correct.
- `raddr` preset to 0x7FF by flush with `waddr` = 0x7FF, then two words written -> reads from 0x7FF then 0x000; `raddr` ends at 0x001.
- `flush` asserted in B1 with `waddr` = 0x123 -> next cycle `tx_valid` = 0, state IDLE, `raddr` = 0x123; `rst` in B2 -> all outputs at reset values.

Source files
------------

// File: rtl/mon_drain_if.sv
// FIFO read port and tagged byte stream seen by the monitor drain engine.
// master = drain engine, slave = FIFO/arbiter and UART side.
interface mon_drain_if;
    logic        empty;
    logic [10:0] waddr;
    logic        rdreq;
    logic        rdack;
    logic [10:0] raddr;
    logic [17:0] rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    modport master (
        input  empty,
        input  waddr,
        input  rdack,
        input  rdata,
        input  tx_ready,
        output rdreq,
        output raddr,
        output tx_valid,
        output tx_data
    );

    modport slave (
        output empty,
        output waddr,
        output rdack,
        output rdata,
        output tx_ready,
        input  rdreq,
        input  raddr,
        input  tx_valid,
        input  tx_data
    );
endinterface

// File: rtl/mon_drain.sv
// Monitor FIFO drain: reads 18-bit samples, emits three tagged bytes each.
// Define MON_DRAIN_SYNC_EN to insert a 0x7E sync byte every 64th word.
module mon_drain (
    input  logic       clk,
    input  logic       rst,
    input  logic       mon_en,
    input  logic       flush,
    output logic       busy,
    mon_drain_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        B0,
        B1,
        B2
`ifdef MON_DRAIN_SYNC_EN
        ,
        SYNC
`endif
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [10:0] raddr_q;
    logic [10:0] raddr_n;
    logic [17:0] word;
    logic [17:0] word_n;
    logic        tx_valid_q;
    logic        tx_valid_n;
    logic [7:0]  tx_data_q;
    logic [7:0]  tx_data_n;
    logic        tx_load;
    logic [7:0]  tx_sel;
    logic        hs;

`ifdef MON_DRAIN_SYNC_EN
    logic [5:0]  sync_cnt;
    logic [5:0]  sync_n;
`endif

    assign hs = tx_valid_q & bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            raddr_q    <= '0;
            word       <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef MON_DRAIN_SYNC_EN
            sync_cnt   <= '0;
`endif
        end else begin
            state      <= state_n;
            raddr_q    <= raddr_n;
            word       <= word_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
`ifdef MON_DRAIN_SYNC_EN
            sync_cnt   <= sync_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        raddr_n    = raddr_q;
        word_n     = word;
        tx_valid_n = tx_valid_q;
        tx_load    = 1'b0;
`ifdef MON_DRAIN_SYNC_EN
        sync_n     = sync_cnt;
`endif
        if (flush) begin
            state_n    = IDLE;
            raddr_n    = bus.waddr;
            tx_valid_n = 1'b0;
`ifdef MON_DRAIN_SYNC_EN
            sync_n     = '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (mon_en && !bus.empty) begin
                        state_n = REQ;
                    end
                end
                REQ: begin
                    if (bus.rdack) begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    word_n     = bus.rdata;
                    raddr_n    = raddr_q + 11'd1;
                    tx_valid_n = 1'b1;
                    tx_load    = 1'b1;
                    state_n    = B0;
`ifdef MON_DRAIN_SYNC_EN
                    sync_n     = sync_cnt + 6'd1;
                    if (sync_cnt == 6'd0) begin
                        state_n = SYNC;
                    end
`endif
                end
                B0: begin
                    if (hs) begin
                        state_n = B1;
                        tx_load = 1'b1;
                    end
                end
                B1: begin
                    if (hs) begin
                        state_n = B2;
                        tx_load = 1'b1;
                    end
                end
                B2: begin
                    if (hs) begin
                        state_n    = IDLE;
                        tx_valid_n = 1'b0;
                    end
                end
`ifdef MON_DRAIN_SYNC_EN
                SYNC: begin
                    if (hs) begin
                        state_n = B0;
                        tx_load = 1'b1;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Byte for the state being entered; word_n already holds the new sample.
    always_comb begin
        tx_sel = tx_data_q;
        unique case (state_n)
            B0:      tx_sel = {2'b11, word_n[17:12]};
            B1:      tx_sel = {2'b10, word_n[11:6]};
            B2:      tx_sel = {2'b00, word_n[5:0]};
`ifdef MON_DRAIN_SYNC_EN
            SYNC:    tx_sel = 8'h7E;
`endif
            default: tx_sel = tx_data_q;
        endcase
        tx_data_n = tx_load ? tx_sel : tx_data_q;
    end

    assign bus.rdreq    = (state == REQ);
    assign bus.raddr    = raddr_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mon_drain.sv
// Scoreboard bench for mon_drain with a behavioural FIFO RAM and arbiter.
// Builds with or without MON_DRAIN_SYNC_EN.
module tb_mon_drain;

    logic clk = 1'b0;
    logic rst;
    logic mon_en;
    logic flush;
    logic busy;

    mon_drain_if bus ();

    mon_drain dut (
        .clk    (clk),
        .rst    (rst),
        .mon_en (mon_en),
        .flush  (flush),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [17:0] mem [0:2047];
    logic [10:0] waddr;
    logic        contend;
    logic        tx_ready;
    logic [17:0] rdata_r = '0;

    assign bus.empty    = (bus.raddr == waddr);
    assign bus.waddr    = waddr;
    assign bus.rdack    = bus.rdreq & ~contend;
    assign bus.rdata    = rdata_r;
    assign bus.tx_ready = tx_ready;

    always @(posedge clk) begin
        if (bus.rdack) rdata_r <= mem[bus.raddr];
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
`ifdef MON_DRAIN_SYNC_EN
    int sync_cnt = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [17:0] d, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
`ifdef MON_DRAIN_SYNC_EN
        if (sync_cnt == 0) exp_q.push_back(8'h7E);
        sync_cnt = (sync_cnt + 1) % 64;
`endif
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        mem[waddr] = d;
        waddr = waddr + 11'd1;
    endtask

    task automatic clear_exp();
        exp_q.delete();
`ifdef MON_DRAIN_SYNC_EN
        sync_cnt = 0;
`endif
    endtask

    task automatic wait_byte(input logic [7:0] b, input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_data == b) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_drained(input string name);
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (!busy && bus.empty) done = 1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Monitor: every handshake cycle consumes one expected byte.
    always @(negedge clk) begin
        if (!rst && bus.tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_byte: got %0h want none", bus.tx_data);
            end else begin
                chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bit found;
        rst = 1'b1;
        mon_en = 1'b1;
        flush = 1'b0;
        contend = 1'b0;
        tx_ready = 1'b1;
        waddr = '0;
        repeat (3) tick();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_rdreq", 32'(bus.rdreq), 0);
        chk("rst_raddr", 32'(bus.raddr), 0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_busy", 32'(busy), 0);

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rdreq || bus.tx_valid) bad++;
        end
        chk("empty_no_rdreq", 32'(bad), 0);
        chk("empty_raddr", 32'(bus.raddr), 0);

        // single word latency
        tick();
        push_word(18'h2A5C3, 8'hEA, 8'h97, 8'h03);
        @(negedge clk);
        @(negedge clk);
        chk("lat_rdreq_n1", 32'(bus.rdreq), 1);
        @(negedge clk);
        chk("lat_wait_n2", 32'(bus.tx_valid), 0);
        @(negedge clk);
        chk("lat_valid_n3", 32'(bus.tx_valid), 1);
`ifdef MON_DRAIN_SYNC_EN
        chk("lat_byte_n3", 32'(bus.tx_data), 32'h7E);
`else
        chk("lat_byte_n3", 32'(bus.tx_data), 32'hEA);
`endif
        wait_drained("drain1");
        chk("raddr_after1", 32'(bus.raddr), 1);

        // stall in B1
        tick();
        push_word(18'h12345, 8'hD2, 8'h8D, 8'h05);
        wait_byte(8'hD2, "stall_b0_seen");
        tick();
        tx_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!(bus.tx_valid && bus.tx_data == 8'h8D)) bad++;
        end
        chk("stall_hold", 32'(bad), 0);
        tick();
        tx_ready = 1'b1;
        wait_drained("drain2");
        chk("raddr_after2", 32'(bus.raddr), 2);

        // write contention in REQ
        tick();
        contend = 1'b1;
        push_word(18'h3F00F, 8'hFF, 8'h80, 8'h0F);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.rdreq) found = 1;
        end
        chk("cont_req_seen", 32'(found), 1);
        repeat (2) begin
            @(negedge clk);
            chk("cont_rdreq_hold", 32'(bus.rdreq), 1);
        end
        tick();
        contend = 1'b0;
        @(negedge clk);
        chk("cont_grant", 32'(bus.rdreq), 1);
        @(negedge clk);
        chk("cont_wait_rdreq", 32'(bus.rdreq), 0);
        chk("cont_wait_valid", 32'(bus.tx_valid), 0);
        @(negedge clk);
        chk("cont_b0_valid", 32'(bus.tx_valid), 1);
        chk("cont_b0_byte", 32'(bus.tx_data), 32'hFF);
        wait_drained("drain3");
        chk("raddr_after3", 32'(bus.raddr), 3);

        // pointer wrap via flush preset
        tick();
        waddr = 11'h7FF;
        flush = 1'b1;
        clear_exp();
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("wrap_preset", 32'(bus.raddr), 32'h7FF);
        chk("wrap_busy", 32'(busy), 0);
        tick();
        push_word(18'h15555, 8'hD5, 8'h95, 8'h15);
        push_word(18'h0AAAA, 8'hCA, 8'hAA, 8'h2A);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus.raddr == 11'h000) found = 1;
        end
        chk("wrap_to_zero", 32'(found), 1);
        wait_drained("drain_wrap");
        chk("raddr_after_wrap", 32'(bus.raddr), 1);

        // mon_en dropped mid-word
        tick();
        push_word(18'h30303, 8'hF0, 8'h8C, 8'h03);
        wait_byte(8'hF0, "en_b0_seen");
        tick();
        mon_en = 1'b0;
        wait_drained("en_word_done");
        tick();
        push_word(18'h00001, 8'hC0, 8'h80, 8'h01);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rdreq || busy) bad++;
        end
        chk("en_off_idle", 32'(bad), 0);
        tick();
        mon_en = 1'b1;
        wait_drained("drain_en");
        chk("raddr_after_en", 32'(bus.raddr), 3);

        // flush in B1
        tick();
        push_word(18'h2A5C3, 8'hEA, 8'h97, 8'h03);
        wait_byte(8'hEA, "fl_b0_seen");
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("fl_b1_byte", 32'(bus.tx_data), 32'h97);
        tick();
        waddr = 11'h123;
        flush = 1'b1;
        clear_exp();
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_tx_valid", 32'(bus.tx_valid), 0);
        chk("fl_busy", 32'(busy), 0);
        chk("fl_raddr", 32'(bus.raddr), 32'h123);
        tx_ready = 1'b1;

        // reset in B2
        tick();
        push_word(18'h00FC0, 8'hC0, 8'hBF, 8'h00);
        wait_byte(8'hBF, "rst_b1_seen");
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("rst_b2_byte", 32'(bus.tx_data), 32'h00);
        chk("rst_b2_valid", 32'(bus.tx_valid), 1);
        tick();
        rst = 1'b1;
        waddr = '0;
        clear_exp();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_rdreq", 32'(bus.rdreq), 0);
        chk("rst2_raddr", 32'(bus.raddr), 0);
        chk("rst2_tx_valid", 32'(bus.tx_valid), 0);
        chk("rst2_tx_data", 32'(bus.tx_data), 0);
        chk("rst2_busy", 32'(busy), 0);
        tx_ready = 1'b1;

        repeat (5) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
